// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial adder.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell stepped LSB first
// over WIDTH cycles, producing sum, carry-out and signed overflow.
module faddr (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] s_next;

  faddr u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
  assign s_next = WIDTH'({fa_s, s_sh_q} >> 1);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = RUN;
          a_sh_d  = bus.a;
          b_sh_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        s_sh_d  = s_next;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // carry_q is the carry into the MSB on this last step.
          state_d = DONE;
          sum_d   = s_next;
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 (directed) and WIDTH=1 (exhaustive).
module tb_serial_add_ctrl;
  typedef struct packed {
    logic [7:0]  sum;
    logic        cout;
    logic        ovf;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] cyc;
  int          n_chk;
  int          n_fail;
  int          done_cnt8;
  int          busy_cnt8;
  int          busy_cnt1;
  exp_t        sb8[$];
  exp_t        sb1[$];

  serial_add_ctrl_if #(.WIDTH(8)) if8 ();
  serial_add_ctrl_if #(.WIDTH(1)) if1 ();

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_add_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= rst ? 32'd0 : cyc + 32'd1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents done.
  always @(negedge clk) begin
    exp_t e;
    if (if8.busy) busy_cnt8++;
    if (if8.done) begin
      done_cnt8++;
      if (sb8.size() == 0) check("w8 spurious done", 32'd1, 32'd0);
      else begin
        e = sb8.pop_front();
        check("w8 sum", 32'(if8.sum), 32'(e.sum));
        check("w8 cout", 32'(if8.cout), 32'(e.cout));
        check("w8 ovf", 32'(if8.ovf), 32'(e.ovf));
        check("w8 done cycle", cyc, e.cyc);
        check("w8 busy cycles", 32'(busy_cnt8), 32'd8);
      end
    end
    if (!if8.busy) busy_cnt8 = 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (if1.busy) busy_cnt1++;
    if (if1.done) begin
      if (sb1.size() == 0) check("w1 spurious done", 32'd1, 32'd0);
      else begin
        e = sb1.pop_front();
        check("w1 sum", 32'(if1.sum), 32'(e.sum[0]));
        check("w1 cout", 32'(if1.cout), 32'(e.cout));
        check("w1 ovf", 32'(if1.ovf), 32'(e.ovf));
        check("w1 done cycle", cyc, e.cyc);
        check("w1 busy cycles", 32'(busy_cnt1), 32'd1);
      end
    end
    if (!if1.busy) busy_cnt1 = 0;
  end

  task automatic load8(input vec_t v);
    if8.sub = v.sub;
    if8.a   = v.a;
    if8.b   = v.b;
    if8.cin = v.cin;
  endtask

  task automatic push8(input vec_t v);
    exp_t e;
    e.sum  = v.sum;
    e.cout = v.cout;
    e.ovf  = v.ovf;
    e.cyc  = cyc + 32'd8;
    sb8.push_back(e);
  endtask

  task automatic op8(input vec_t v);
    @(negedge clk);
    load8(v);
    if8.start = 1'b1;
    @(posedge clk);
    #1;
    push8(v);
    if8.start = 1'b0;
    if8.a     = ~if8.a;
    if8.b     = ~if8.b;
    if8.cin   = ~if8.cin;
  endtask

  task automatic wait_idle8();
    int n = 0;
    while ((sb8.size() != 0 || if8.busy || if8.done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("w8 idle timeout", 32'(n >= 100), 32'd0);
  endtask

  task automatic op1(input logic sub, input logic a, input logic b, input logic cin);
    exp_t        e;
    logic        bb;
    logic        c0;
    logic [1:0]  full;
    int          n = 0;
    bb   = sub ? ~b : b;
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + 2'(c0);
    @(negedge clk);
    if1.sub = sub; if1.a = a; if1.b = b; if1.cin = cin; if1.start = 1'b1;
    @(posedge clk);
    #1;
    e.sum  = 8'(full[0]);
    e.cout = full[1];
    e.ovf  = c0 ^ full[1];
    e.cyc  = cyc + 32'd1;
    sb1.push_back(e);
    if1.start = 1'b0;
    if1.a = ~a; if1.b = ~b; if1.cin = ~cin;
    while ((sb1.size() != 0 || if1.busy || if1.done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w1 idle timeout", 32'(n >= 20), 32'd0);
  endtask

  vec_t dir[6];
  vec_t held[3];
  int   d0;

  initial begin
    n_chk = 0; n_fail = 0; done_cnt8 = 0; busy_cnt8 = 0; busy_cnt1 = 0;
    if8.start = 1'b0; if8.sub = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if1.start = 1'b0; if1.sub = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;

    //        sub   a      b      cin   sum    cout  ovf
    dir[0] = {1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    dir[1] = {1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    dir[2] = {1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    dir[3] = {1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    dir[4] = {1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    dir[5] = {1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    held[0] = dir[0];
    held[1] = dir[3];
    held[2] = dir[2];

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(if8.busy), 32'd0);
    check("reset done", 32'(if8.done), 32'd0);
    check("reset sum", 32'(if8.sum), 32'd0);
    check("reset cout", 32'(if8.cout), 32'd0);
    check("reset ovf", 32'(if8.ovf), 32'd0);
    check("reset w1 sum", 32'(if1.sum), 32'd0);
    rst = 1'b0;

    // Directed add/sub vectors, one at a time.
    op8(dir[0]);
    wait_idle8();
    repeat (3) @(negedge clk);
    check("sum held in idle", 32'(if8.sum), 32'h96);
    for (int i = 1; i < 5; i++) begin
      op8(dir[i]);
      wait_idle8();
    end

    // Start re-pulsed mid-run with other operands must be ignored.
    d0 = done_cnt8;
    op8(dir[5]);
    repeat (3) @(negedge clk);
    check("sum held in run", 32'(if8.sum), 32'h7F);
    if8.a = 8'hFF; if8.b = 8'hFF; if8.sub = 1'b1; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    wait_idle8();
    repeat (4) @(negedge clk);
    check("mid-run start done count", 32'(done_cnt8 - d0), 32'd1);

    // Reset during RUN discards the op and clears results.
    op8(dir[4]);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(sb8.pop_back());
    @(posedge clk);
    @(negedge clk);
    check("rst-run busy", 32'(if8.busy), 32'd0);
    check("rst-run done", 32'(if8.done), 32'd0);
    check("rst-run sum", 32'(if8.sum), 32'd0);
    check("rst-run cout", 32'(if8.cout), 32'd0);
    check("rst-run ovf", 32'(if8.ovf), 32'd0);
    rst = 1'b0;
    op8({1'b1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b1, 1'b0});
    wait_idle8();

    // Start held high: back-to-back ops every WIDTH+1 cycles.
    @(negedge clk);
    load8(held[0]);
    if8.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      push8(held[i]);
      if (i < 2) begin
        load8(held[i + 1]);
        repeat (8) @(posedge clk);
      end else begin
        if8.start = 1'b0;
      end
    end
    wait_idle8();

    // WIDTH=1 exhaustive against the bench model.
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kk;
      kk = 4'(k);
      op1(kk[3], kk[2], kk[1], kk[0]);
    end

    check("w8 scoreboard empty", 32'(sb8.size()), 32'd0);
    check("w1 scoreboard empty", 32'(sb1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
